cam_match_encoder: RTL and testbench



---
 rtl/cam_match_encoder.sv | 99 +++++++++
 tb/tb_cam_match_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_encoder.sv
// 8-entry content-addressable match array with a two-stage
// search pipeline: registered match vector, then priority encode.
module cam_match_encoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              inv_en,
  input  logic [2:0]        wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              search_valid,
  input  logic [DATA_W-1:0] search_key,
  output logic              search_ready,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [7:0]        result_match,
  output logic [2:0]        result_index,
  output logic              result_hit,
  output logic              result_multi
);

  localparam int N = 8;
  localparam logic [N-1:0] ONE = N'(1);

  logic [DATA_W-1:0] entry [N];
  logic [N-1:0]      valid;
  logic [N-1:0]      match;
  logic              s1_valid;
  logic [N-1:0]      s1_match;
  logic              out_adv;
  logic [2:0]        enc_index;
  logic              enc_hit;
  logic              enc_multi;

  assign out_adv      = !result_valid || result_ready;
  assign search_ready = !s1_valid || out_adv;

  // compare the key against pre-edge contents; invalid entries never hit
  always_comb begin
    match = '0;
    for (int i = 0; i < N; i++) begin
      match[i] = valid[i] && (entry[i] == search_key);
    end
  end

  // lowest set bit wins; multi means more than one bit set
  always_comb begin
    enc_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s1_match[i]) enc_index = 3'(i);
    end
    enc_hit   = |s1_match;
    enc_multi = |(s1_match & (s1_match - ONE));
  end

  // entry storage; invalidate beats a same-cycle write on the valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) entry[i] <= '0;
      valid <= '0;
    end else begin
      if (wr_en) entry[wr_index] <= wr_data;
      if (inv_en) valid[wr_index] <= 1'b0;
      else if (wr_en) valid[wr_index] <= 1'b1;
    end
  end

  // stage 1: capture the match vector whenever the slot can move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
    end else if (search_ready) begin
      s1_valid <= search_valid;
      s1_match <= search_valid ? match : '0;
    end
  end

  // stage 2: encoded result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_match <= '0;
      result_index <= '0;
      result_hit   <= 1'b0;
      result_multi <= 1'b0;
    end else if (out_adv) begin
      result_valid <= s1_valid;
      if (s1_valid) begin
        result_match <= s1_match;
        result_index <= enc_index;
        result_hit   <= enc_hit;
        result_multi <= enc_multi;
      end
    end
  end

endmodule

// File: tb/tb_cam_match_encoder.sv
// Scoreboard bench for cam_match_encoder: directed searches push
// hand-computed results; a monitor pops them on each handshake.
module tb_cam_match_encoder;

  typedef struct packed {
    logic [7:0] m;
    logic [2:0] idx;
    logic       hit;
    logic       multi;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       inv_en;
  logic [2:0] wr_index;
  logic [7:0] wr_data;
  logic       search_valid;
  logic [7:0] search_key;
  logic       search_ready;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result_match;
  logic [2:0] result_index;
  logic       result_hit;
  logic       result_multi;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t held;
  logic stalled = 1'b0;

  cam_match_encoder #(.DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .inv_en(inv_en),
    .wr_index(wr_index),
    .wr_data(wr_data),
    .search_valid(search_valid),
    .search_key(search_key),
    .search_ready(search_ready),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_match(result_match),
    .result_index(result_index),
    .result_hit(result_hit),
    .result_multi(result_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t cur();
    exp_t c;
    c.m     = result_match;
    c.idx   = result_index;
    c.hit   = result_hit;
    c.multi = result_multi;
    return c;
  endfunction

  function automatic exp_t mk(input logic [7:0] m, input logic [2:0] i,
                              input logic h, input logic mu);
    exp_t e;
    e.m = m; e.idx = i; e.hit = h; e.multi = mu;
    return e;
  endfunction

  // monitor: pop on handshake, and demand stable outputs while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!result_valid || cur() != held) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h want v=1 %h",
                   result_valid, cur(), held);
        end
      end
      if (result_valid && result_ready) begin
        stalled = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h want none", cur());
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cur() != e) begin
            errors++;
            $display("FAIL result: got m=%h i=%0d h=%0b mu=%0b want m=%h i=%0d h=%0b mu=%0b",
                     result_match, result_index, result_hit, result_multi,
                     e.m, e.idx, e.hit, e.multi);
          end
        end
      end else if (result_valid) begin
        stalled = 1'b1;
        held = cur();
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, int'(result_valid), 0);
    chk({name, "_match"}, int'(result_match), 0);
    chk({name, "_index"}, int'(result_index), 0);
    chk({name, "_hit"}, int'(result_hit), 0);
    chk({name, "_multi"}, int'(result_multi), 0);
    chk({name, "_sready"}, int'(search_ready), 1);
  endtask

  // call at posedge+1; returns at posedge+1 after the write edge
  task automatic wr(input logic [2:0] idx, input logic [7:0] d,
                    input logic w, input logic inv);
    wr_en = w; inv_en = inv; wr_index = idx; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0; inv_en = 1'b0;
  endtask

  // call at posedge+1; returns at posedge+1 after the accept edge
  task automatic do_search(input logic [7:0] key, input exp_t e);
    int n;
    n = 0;
    search_valid = 1'b1;
    search_key = key;
    @(negedge clk);
    while (!search_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!search_ready) begin
      checks++;
      errors++;
      $display("FAIL search_accept_timeout: got ready=0 want ready=1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    search_valid = 1'b0;
  endtask

  exp_t none;

  initial begin
    none = mk(8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    wr_en = 0; inv_en = 0; wr_index = 0; wr_data = 0;
    search_valid = 0; search_key = 0; result_ready = 1'b1;
    #2;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // empty table: zero key must still miss; check 2-cycle latency
    do_search(8'h00, none);
    @(negedge clk);
    chk("latency_c1", int'(result_valid), 0);
    @(negedge clk);
    chk("latency_c2", int'(result_valid), 1);
    @(posedge clk); #1;

    wr(3'd5, 8'hA5, 1'b1, 1'b0);
    do_search(8'hA5, mk(8'h20, 3'd5, 1'b1, 1'b0));

    wr(3'd2, 8'h3C, 1'b1, 1'b0);
    wr(3'd6, 8'h3C, 1'b1, 1'b0);
    do_search(8'h3C, mk(8'h44, 3'd2, 1'b1, 1'b1));
    wr(3'd2, 8'h00, 1'b0, 1'b1);
    do_search(8'h3C, mk(8'h40, 3'd6, 1'b1, 1'b0));

    // write and invalidate together: data lands, entry stays invalid
    wr(3'd3, 8'h11, 1'b1, 1'b1);
    do_search(8'h11, none);

    // overwrite a valid entry
    wr(3'd5, 8'h5A, 1'b1, 1'b0);
    do_search(8'h5A, mk(8'h20, 3'd5, 1'b1, 1'b0));
    do_search(8'hA5, none);

    // back-to-back searches into a stalled consumer
    repeat (4) @(posedge clk);
    #1 result_ready = 1'b0;
    do_search(8'h3C, mk(8'h40, 3'd6, 1'b1, 1'b0));
    do_search(8'h5A, mk(8'h20, 3'd5, 1'b1, 1'b0));
    @(negedge clk);
    chk("stall_sready", int'(search_ready), 0);
    chk("stall_rvalid", int'(result_valid), 1);
    repeat (2) @(posedge clk);
    #1 result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // write and search in the same cycle: search sees old contents
    wr_en = 1'b1; wr_index = 3'd1; wr_data = 8'h77;
    do_search(8'h77, none);
    wr_en = 1'b0;
    do_search(8'h77, mk(8'h02, 3'd1, 1'b1, 1'b0));
    repeat (4) @(posedge clk);
    #1;

    // reset with two searches in flight
    do_search(8'h3C, mk(8'h40, 3'd6, 1'b1, 1'b0));
    do_search(8'h5A, mk(8'h20, 3'd5, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(result_valid), 0);
    end
    @(posedge clk); #1;
    do_search(8'h5A, none);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
